rate_sequencer: RTL and testbench

//  Run/pause and speed controller for the image-generator tick datapath.

---
 rtl/rate_sequencer.sv | 130 +++++++++++++
 tb/tb_rate_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/rate_sequencer.sv
// rate_sequencer: run/pause and four-level rate divider driving a 1-cycle tick enable.
// Define RATE_SEQ_STEP_EN to enable single-step ticks from step_btn while paused.
module rate_sequencer #(
  parameter int CNT_W     = 23,
  parameter int DIV_SLOW  = 8,
  parameter int DIV_MED   = 4,
  parameter int DIV_FAST  = 2,
  parameter int DIV_TURBO = 1
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       speed_btn,
  input  logic       pause_btn,
  input  logic       step_btn,
  output logic       tick,
  output logic [1:0] level,
  output logic       running,
  output logic       wrap
);

  // state | meaning
  // RUN   | divider advancing, tick fires at terminal count
  // PAUSE | divider held, tick only from a single-step press
  typedef enum logic {RUN, PAUSE} state_t;

  // A ratio of 0 behaves as 1 so the divider never stalls.
  localparam int D_SLOW  = (DIV_SLOW  == 0) ? 1 : DIV_SLOW;
  localparam int D_MED   = (DIV_MED   == 0) ? 1 : DIV_MED;
  localparam int D_FAST  = (DIV_FAST  == 0) ? 1 : DIV_FAST;
  localparam int D_TURBO = (DIV_TURBO == 0) ? 1 : DIV_TURBO;

  state_t state, state_nxt;

  logic speed_s1, speed_s2, speed_s2_d;
  logic pause_s1, pause_s2, pause_s2_d;
  logic speed_press, pause_press, step_press;

  logic [CNT_W-1:0] count, count_nxt, div_m1;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      speed_s1   <= 1'b0;
      speed_s2   <= 1'b0;
      speed_s2_d <= 1'b0;
      pause_s1   <= 1'b0;
      pause_s2   <= 1'b0;
      pause_s2_d <= 1'b0;
    end else begin
      speed_s1   <= speed_btn;
      speed_s2   <= speed_s1;
      speed_s2_d <= speed_s2;
      pause_s1   <= pause_btn;
      pause_s2   <= pause_s1;
      pause_s2_d <= pause_s2;
    end
  end

  assign speed_press = speed_s2 & ~speed_s2_d;
  assign pause_press = pause_s2 & ~pause_s2_d;

`ifdef RATE_SEQ_STEP_EN
  logic step_s1, step_s2, step_s2_d;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      step_s1   <= 1'b0;
      step_s2   <= 1'b0;
      step_s2_d <= 1'b0;
    end else begin
      step_s1   <= step_btn;
      step_s2   <= step_s1;
      step_s2_d <= step_s2;
    end
  end

  assign step_press = step_s2 & ~step_s2_d;
`else
  logic unused_step;
  assign unused_step = step_btn;
  assign step_press  = 1'b0;
`endif

  always_comb begin
    div_m1 = '0;
    case (level)
      2'd0:    div_m1 = CNT_W'(D_SLOW - 1);
      2'd1:    div_m1 = CNT_W'(D_MED - 1);
      2'd2:    div_m1 = CNT_W'(D_FAST - 1);
      default: div_m1 = CNT_W'(D_TURBO - 1);
    endcase
  end

  // A speed press restarts the divider and suppresses the tick, overriding step.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    tick      = 1'b0;
    if (pause_press) state_nxt = (state == RUN) ? PAUSE : RUN;
    if (speed_press) begin
      count_nxt = '0;
    end else if (state == RUN) begin
      if (count >= div_m1) begin
        tick      = 1'b1;
        count_nxt = '0;
      end else begin
        count_nxt = count + 1'b1;
      end
    end else if (step_press) begin
      tick      = 1'b1;
      count_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= RUN;
      count <= '0;
      level <= 2'd0;
      wrap  <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      wrap  <= speed_press && (level == 2'd3);
      if (speed_press) level <= level + 2'd1;
    end
  end

  assign running = (state == RUN);

endmodule

// File: tb/tb_rate_sequencer.sv
// Directed bench for rate_sequencer: rate levels, wrap, pause/resume, simultaneous presses, step.
// Expectations follow RATE_SEQ_STEP_EN when the macro is defined for the build.
module tb_rate_sequencer;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       speed_btn = 1'b0;
  logic       pause_btn = 1'b0;
  logic       step_btn = 1'b0;
  logic       tick;
  logic [1:0] level;
  logic       running;
  logic       wrap;

  int n_checks = 0;
  int n_fail   = 0;

  rate_sequencer dut (
    .clk       (clk),
    .nrst      (nrst),
    .speed_btn (speed_btn),
    .pause_btn (pause_btn),
    .step_btn  (step_btn),
    .tick      (tick),
    .level     (level),
    .running   (running),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step_cyc();
    @(posedge clk);
    #1;
  endtask

  // Asserts reset mid-cycle, checks outputs immediately, releases between edges (count=0 now).
  task automatic do_reset(input string tag);
    nrst = 1'b0;
    #2;
    chk({tag, "_rst_tick"}, tick, 0);
    chk({tag, "_rst_level"}, level, 0);
    chk({tag, "_rst_running"}, running, 1);
    chk({tag, "_rst_wrap"}, wrap, 0);
    step_cyc();
    step_cyc();
    nrst = 1'b1;
  endtask

  // Press lands two edges after raising; tk is the tick in the press cycle; returns after the update edge.
  task automatic press(input logic sp, input logic pa, input logic st, output logic tk);
    speed_btn = sp;
    pause_btn = pa;
    step_btn  = st;
    step_cyc();
    step_cyc();
    tk = tick;
    step_cyc();
    speed_btn = 1'b0;
    pause_btn = 1'b0;
    step_btn  = 1'b0;
  endtask

  task automatic observe(input int n, output int ticks, output int first, output int wraps);
    ticks = 0;
    first = -1;
    wraps = 0;
    for (int i = 0; i < n; i++) begin
      if (tick) begin
        ticks++;
        if (first < 0) first = i;
      end
      if (wrap) wraps++;
      step_cyc();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic tk;
    int   ticks, first, wraps;

    #1;
    do_reset("t0");

    // Level 0 rate, then one speed press to level 1
    observe(40, ticks, first, wraps);
    chk("t2_slow_ticks", ticks, 5);
    chk("t2_slow_first", first, 7);
    press(1, 0, 0, tk);
    chk("t2_press_tick", tk, 0);
    chk("t2_level", level, 1);
    observe(12, ticks, first, wraps);
    chk("t2_med_ticks", ticks, 3);
    chk("t2_med_first", first, 3);

    // Level walk with wrap
    do_reset("t3");
    press(1, 0, 0, tk);
    chk("t3_l1", level, 1);
    chk("t3_w1", wrap, 0);
    step_cyc();
    press(1, 0, 0, tk);
    chk("t3_l2", level, 2);
    chk("t3_w2", wrap, 0);
    step_cyc();
    press(1, 0, 0, tk);
    chk("t3_l3", level, 3);
    chk("t3_w3", wrap, 0);
    observe(5, ticks, first, wraps);
    chk("t3_turbo_ticks", ticks, 5);
    chk("t3_turbo_wraps", wraps, 0);
    press(1, 0, 0, tk);
    chk("t3_wrap_press_tick", tk, 0);
    chk("t3_l0", level, 0);
    chk("t3_wrap_pulse", wrap, 1);
    step_cyc();
    chk("t3_wrap_drop", wrap, 0);

    // Reset while at level 3 with tick high
    for (int i = 0; i < 3; i++) begin
      step_cyc();
      press(1, 0, 0, tk);
    end
    chk("t1_pre_level", level, 3);
    chk("t1_pre_tick", tick, 1);
    do_reset("t1");

    // Pause at count 5, hold, resume from held count 6
    step_cyc();
    step_cyc();
    step_cyc();
    press(0, 1, 0, tk);
    chk("t4_press_tick", tk, 0);
    chk("t4_paused", running, 0);
    observe(20, ticks, first, wraps);
    chk("t4_pause_ticks", ticks, 0);
    press(0, 1, 0, tk);
    chk("t4_resumed", running, 1);
    observe(10, ticks, first, wraps);
    chk("t4_resume_first", first, 1);
    chk("t4_resume_ticks", ticks, 2);

    // Pause press while count = DIV-1: tick still fires
    do_reset("t7");
    for (int i = 0; i < 5; i++) step_cyc();
    press(0, 1, 0, tk);
    chk("t7_tc_tick", tk, 1);
    chk("t7_paused", running, 0);
    chk("t7_paused_tick", tick, 0);
    do_reset("t7b");

    // Speed and pause in the same cycle from RUN at level 1, natural tick suppressed
    press(1, 0, 0, tk);
    chk("t5_l1", level, 1);
    step_cyc();
    press(1, 1, 0, tk);
    chk("t5_press_tick", tk, 0);
    chk("t5_level", level, 2);
    chk("t5_running", running, 0);
    chk("t5_tick", tick, 0);
    step_cyc();
    press(0, 1, 0, tk);
    chk("t5_resumed", running, 1);
    observe(4, ticks, first, wraps);
    chk("t5_first", first, 1);
    chk("t5_ticks", ticks, 2);

    // Single-step in PAUSE, speed wins over step, step ignored in RUN
    do_reset("t6");
    press(0, 1, 0, tk);
    chk("t6_paused", running, 0);
    ticks = 0;
    for (int i = 0; i < 3; i++) begin
      step_cyc();
      press(0, 0, 1, tk);
      if (tk) ticks++;
      if (tick) ticks++;
    end
`ifdef RATE_SEQ_STEP_EN
    chk("t6_step_ticks", ticks, 3);
`else
    chk("t6_step_ticks", ticks, 0);
`endif
    observe(5, ticks, first, wraps);
    chk("t6_idle_ticks", ticks, 0);
    step_cyc();
    press(1, 0, 1, tk);
    chk("t6_speed_step_tick", tk, 0);
    chk("t6_speed_step_level", level, 1);
    do_reset("t6b");
    step_btn = 1'b1;
    observe(16, ticks, first, wraps);
    step_btn = 1'b0;
    chk("t6_run_ticks", ticks, 2);
    chk("t6_run_first", first, 7);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
